// File: rtl/display_timing_gen.sv
// rtl/display_timing_gen.sv - runtime-reprogrammable pixel timing generator
// Frame-boundary config apply through a shadow set, optional equal-latency output delay line.
module display_timing_gen #(
  parameter int CW         = 12,
  parameter int DEF_H_RES  = 640,
  parameter int DEF_H_FP   = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP   = 48,
  parameter int DEF_V_RES  = 480,
  parameter int DEF_V_FP   = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP   = 33,
  parameter bit DEF_H_POL  = 1'b0,
  parameter bit DEF_V_POL  = 1'b0,
  parameter int PIPE_DELAY = 0,
  parameter int FCW        = 16
) (
  input  logic                 i_pixel_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_cfg_wr,
  input  logic [CW-1:0]        i_cfg_h_res,
  input  logic [CW-1:0]        i_cfg_h_fp,
  input  logic [CW-1:0]        i_cfg_h_sync,
  input  logic [CW-1:0]        i_cfg_h_bp,
  input  logic [CW-1:0]        i_cfg_v_res,
  input  logic [CW-1:0]        i_cfg_v_fp,
  input  logic [CW-1:0]        i_cfg_v_sync,
  input  logic [CW-1:0]        i_cfg_v_bp,
  input  logic                 i_cfg_h_pol,
  input  logic                 i_cfg_v_pol,
  output logic [2:0]           o_hvesync,
  output logic                 o_frame_start,
  output logic                 o_line_start,
  output logic signed [CW:0]   o_x,
  output logic signed [CW:0]   o_y,
  output logic [FCW-1:0]       o_frame_count,
  output logic                 o_cfg_pending,
  output logic                 o_cfg_err
);

  typedef struct packed {
    logic [CW-1:0] h_res;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_res;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
    logic          h_pol;
    logic          v_pol;
  } timing_t;

  typedef struct packed {
    logic [2:0]  hvesync;
    logic        frame_start;
    logic        line_start;
    logic [CW:0] x;
    logic [CW:0] y;
  } tap_t;

  localparam timing_t DEF_TIMING = '{
    h_res:  CW'(DEF_H_RES),  h_fp: CW'(DEF_H_FP), h_sync: CW'(DEF_H_SYNC), h_bp: CW'(DEF_H_BP),
    v_res:  CW'(DEF_V_RES),  v_fp: CW'(DEF_V_FP), v_sync: CW'(DEF_V_SYNC), v_bp: CW'(DEF_V_BP),
    h_pol:  DEF_H_POL,       v_pol: DEF_V_POL
  };
  localparam logic signed [CW:0] S_ONE = (CW+1)'(1);
  localparam logic [CW-1:0]      ZERO  = {CW{1'b0}};

  // Blanking coordinates are negative offsets from the first active pixel.
  function automatic logic signed [CW:0] neg_sum3(input logic [CW-1:0] a,
                                                  input logic [CW-1:0] b,
                                                  input logic [CW-1:0] c);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return -$signed(s);
  endfunction

  timing_t            act;
  timing_t            shadow;
  timing_t            wr_timing;
  timing_t            next_act;
  logic               pending;
  logic               cfg_err;
  logic               wr_valid;
  logic               h_last;
  logic               v_last;
  logic               frame_wrap;
  logic               hsync;
  logic               vsync;
  logic signed [CW:0] x;
  logic signed [CW:0] y;
  logic signed [CW:0] h_start;
  logic signed [CW:0] v_start;
  logic signed [CW:0] hs_start;
  logic signed [CW:0] hs_end;
  logic signed [CW:0] vs_start;
  logic signed [CW:0] vs_end;
  logic signed [CW:0] h_max;
  logic signed [CW:0] v_max;
  logic signed [CW:0] next_h_start;
  logic signed [CW:0] next_v_start;
  logic [FCW-1:0]     frame_count;
  tap_t               cur_tap;
  tap_t               out_tap;
  tap_t               reset_tap;

  assign wr_timing = '{
    h_res: i_cfg_h_res, h_fp: i_cfg_h_fp, h_sync: i_cfg_h_sync, h_bp: i_cfg_h_bp,
    v_res: i_cfg_v_res, v_fp: i_cfg_v_fp, v_sync: i_cfg_v_sync, v_bp: i_cfg_v_bp,
    h_pol: i_cfg_h_pol, v_pol: i_cfg_v_pol
  };
  assign wr_valid = (|i_cfg_h_res) && (|i_cfg_h_sync) && (|i_cfg_v_res) && (|i_cfg_v_sync);

  assign h_start  = neg_sum3(act.h_fp, act.h_sync, act.h_bp);
  assign v_start  = neg_sum3(act.v_fp, act.v_sync, act.v_bp);
  assign hs_start = neg_sum3(ZERO, act.h_sync, act.h_bp);
  assign vs_start = neg_sum3(ZERO, act.v_sync, act.v_bp);
  assign hs_end   = neg_sum3(ZERO, ZERO, act.h_bp);
  assign vs_end   = neg_sum3(ZERO, ZERO, act.v_bp);
  assign h_max    = $signed({1'b0, act.h_res}) - S_ONE;
  assign v_max    = $signed({1'b0, act.v_res}) - S_ONE;

  assign h_last     = (x == h_max);
  assign v_last     = (y == v_max);
  assign frame_wrap = i_enable && h_last && v_last;

  // The first pixel of a new frame must already use the newly applied timing.
  assign next_act     = (frame_wrap && pending) ? shadow : act;
  assign next_h_start = neg_sum3(next_act.h_fp, next_act.h_sync, next_act.h_bp);
  assign next_v_start = neg_sum3(next_act.v_fp, next_act.v_sync, next_act.v_bp);

  assign hsync = (x >= hs_start && x < hs_end) ? act.h_pol : !act.h_pol;
  assign vsync = (y >= vs_start && y < vs_end) ? act.v_pol : !act.v_pol;

  assign cur_tap = '{
    hvesync:     {(!x[CW] && !y[CW]), vsync, hsync},
    frame_start: (x == h_start) && (y == v_start),
    line_start:  (x == h_start),
    x:           x,
    y:           y
  };

  assign reset_tap = '{
    hvesync:     {1'b0, !DEF_V_POL, !DEF_H_POL},
    frame_start: 1'b0,
    line_start:  1'b0,
    x:           neg_sum3(DEF_TIMING.h_fp, DEF_TIMING.h_sync, DEF_TIMING.h_bp),
    y:           neg_sum3(DEF_TIMING.v_fp, DEF_TIMING.v_sync, DEF_TIMING.v_bp)
  };

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      act         <= DEF_TIMING;
      shadow      <= '0;
      pending     <= 1'b0;
      cfg_err     <= 1'b0;
      x           <= $signed(reset_tap.x);
      y           <= $signed(reset_tap.y);
      frame_count <= '0;
    end else begin
      cfg_err <= i_cfg_wr && !wr_valid;
      if (i_enable) begin
        if (h_last) begin
          x <= next_h_start;
          if (v_last) begin
            y           <= next_v_start;
            act         <= next_act;
            frame_count <= frame_count + FCW'(1);
          end else begin
            y <= y + S_ONE;
          end
        end else begin
          x <= x + S_ONE;
        end
      end
      // A write landing on the apply cycle re-arms pending for the following wrap.
      if (i_cfg_wr && wr_valid) begin
        shadow  <= wr_timing;
        pending <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign out_tap = cur_tap;
    end else begin : g_delay
      tap_t stages [PIPE_DELAY];
      always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
          for (int k = 0; k < PIPE_DELAY; k++) stages[k] <= reset_tap;
        end else if (i_enable) begin
          stages[0] <= cur_tap;
          for (int k = 1; k < PIPE_DELAY; k++) stages[k] <= stages[k-1];
        end
      end
      assign out_tap = stages[PIPE_DELAY-1];
    end
  endgenerate

  assign o_hvesync     = out_tap.hvesync;
  assign o_frame_start = out_tap.frame_start;
  assign o_line_start  = out_tap.line_start;
  assign o_x           = $signed(out_tap.x);
  assign o_y           = $signed(out_tap.y);
  assign o_frame_count = frame_count;
  assign o_cfg_pending = pending;
  assign o_cfg_err     = cfg_err;

endmodule

// File: tb/tb_display_timing_gen.sv
// tb/tb_display_timing_gen.sv - scoreboard bench for display_timing_gen
// Small-timing instances (delay 0 and 3) plus a default-timing instance.
module tb_display_timing_gen;
  localparam int CW  = 12;
  localparam int FCW = 16;

  typedef struct {int hr, hf, hs, hb, vr, vf, vs, vb; logic hp, vp;} tcfg_t;
  typedef struct {logic [2:0] hve; logic ls, fs; int x, y;} out_t;
  typedef struct {out_t d0; out_t d3; int fc; logic pend; logic err;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, wr, c_hp, c_vp;
  logic [CW-1:0] c_hr, c_hf, c_hs, c_hb, c_vr, c_vf, c_vs, c_vb;

  logic [2:0] d0_hve, d3_hve, dd_hve;
  logic d0_fs, d0_ls, d3_fs, d3_ls, dd_fs, dd_ls;
  logic signed [CW:0] d0_x, d0_y, d3_x, d3_y, dd_x, dd_y;
  logic [FCW-1:0] d0_fc, d3_fc, dd_fc;
  logic d0_pend, d3_pend, dd_pend, d0_err, d3_err, dd_err;

  display_timing_gen #(.DEF_H_RES(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(1),
    .DEF_V_RES(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(2), .PIPE_DELAY(0)) u_d0 (
    .i_pixel_clk(clk), .i_reset(rst), .i_enable(en), .i_cfg_wr(wr),
    .i_cfg_h_res(c_hr), .i_cfg_h_fp(c_hf), .i_cfg_h_sync(c_hs), .i_cfg_h_bp(c_hb),
    .i_cfg_v_res(c_vr), .i_cfg_v_fp(c_vf), .i_cfg_v_sync(c_vs), .i_cfg_v_bp(c_vb),
    .i_cfg_h_pol(c_hp), .i_cfg_v_pol(c_vp), .o_hvesync(d0_hve), .o_frame_start(d0_fs),
    .o_line_start(d0_ls), .o_x(d0_x), .o_y(d0_y), .o_frame_count(d0_fc),
    .o_cfg_pending(d0_pend), .o_cfg_err(d0_err));

  display_timing_gen #(.DEF_H_RES(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(1),
    .DEF_V_RES(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(2), .PIPE_DELAY(3)) u_d3 (
    .i_pixel_clk(clk), .i_reset(rst), .i_enable(en), .i_cfg_wr(wr),
    .i_cfg_h_res(c_hr), .i_cfg_h_fp(c_hf), .i_cfg_h_sync(c_hs), .i_cfg_h_bp(c_hb),
    .i_cfg_v_res(c_vr), .i_cfg_v_fp(c_vf), .i_cfg_v_sync(c_vs), .i_cfg_v_bp(c_vb),
    .i_cfg_h_pol(c_hp), .i_cfg_v_pol(c_vp), .o_hvesync(d3_hve), .o_frame_start(d3_fs),
    .o_line_start(d3_ls), .o_x(d3_x), .o_y(d3_y), .o_frame_count(d3_fc),
    .o_cfg_pending(d3_pend), .o_cfg_err(d3_err));

  display_timing_gen u_dd (
    .i_pixel_clk(clk), .i_reset(rst), .i_enable(en), .i_cfg_wr(1'b0),
    .i_cfg_h_res(c_hr), .i_cfg_h_fp(c_hf), .i_cfg_h_sync(c_hs), .i_cfg_h_bp(c_hb),
    .i_cfg_v_res(c_vr), .i_cfg_v_fp(c_vf), .i_cfg_v_sync(c_vs), .i_cfg_v_bp(c_vb),
    .i_cfg_h_pol(c_hp), .i_cfg_v_pol(c_vp), .o_hvesync(dd_hve), .o_frame_start(dd_fs),
    .o_line_start(dd_ls), .o_x(dd_x), .o_y(dd_y), .o_frame_count(dd_fc),
    .o_cfg_pending(dd_pend), .o_cfg_err(dd_err));

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  tcfg_t cfg_a, cfg_b, cfg_c, cfg_bad;
  tcfg_t m_act, m_sh;
  logic m_pend, m_err;
  int mx, my, m_fc;
  out_t m_pipe[3];
  out_t rst_tap;

  function automatic out_t und(tcfg_t t, int x, int y);
    out_t o;
    o.hve[0] = (x >= -(t.hs + t.hb) && x < -t.hb) ? t.hp : ~t.hp;
    o.hve[1] = (y >= -(t.vs + t.vb) && y < -t.vb) ? t.vp : ~t.vp;
    o.hve[2] = (x >= 0) && (y >= 0);
    o.ls = (x == -(t.hf + t.hs + t.hb));
    o.fs = o.ls && (y == -(t.vf + t.vs + t.vb));
    o.x = x;
    o.y = y;
    return o;
  endfunction

  task automatic drive(input tcfg_t t);
    c_hr = CW'(t.hr); c_hf = CW'(t.hf); c_hs = CW'(t.hs); c_hb = CW'(t.hb);
    c_vr = CW'(t.vr); c_vf = CW'(t.vf); c_vs = CW'(t.vs); c_vb = CW'(t.vb);
    c_hp = t.hp; c_vp = t.vp;
  endtask

  task automatic model_edge();
    out_t cur;
    logic ok;
    if (rst) begin
      m_act = cfg_a; m_sh = '{default: 0}; m_pend = 1'b0; m_err = 1'b0; m_fc = 0;
      mx = -(cfg_a.hf + cfg_a.hs + cfg_a.hb);
      my = -(cfg_a.vf + cfg_a.vs + cfg_a.vb);
      for (int k = 0; k < 3; k++) m_pipe[k] = rst_tap;
    end else begin
      cur = und(m_act, mx, my);
      ok = (c_hr != 0) && (c_hs != 0) && (c_vr != 0) && (c_vs != 0);
      m_err = wr && !ok;
      if (en) begin
        m_pipe[2] = m_pipe[1]; m_pipe[1] = m_pipe[0]; m_pipe[0] = cur;
        if (mx == m_act.hr - 1 && my == m_act.vr - 1) begin
          if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
          m_fc = (m_fc + 1) % 65536;
          mx = -(m_act.hf + m_act.hs + m_act.hb);
          my = -(m_act.vf + m_act.vs + m_act.vb);
        end else if (mx == m_act.hr - 1) begin
          mx = -(m_act.hf + m_act.hs + m_act.hb);
          my = my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      if (wr && ok) begin
        m_sh.hr = int'(c_hr); m_sh.hf = int'(c_hf); m_sh.hs = int'(c_hs); m_sh.hb = int'(c_hb);
        m_sh.vr = int'(c_vr); m_sh.vf = int'(c_vf); m_sh.vs = int'(c_vs); m_sh.vb = int'(c_vb);
        m_sh.hp = c_hp; m_sh.vp = c_vp;
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    e.d0 = und(m_act, mx, my); e.d3 = m_pipe[2];
    e.fc = m_fc; e.pend = m_pend; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_apply(input string name, input int exp_n);
    int n;
    n = 0;
    while (d0_pend && n < 400) begin cyc(); n++; end
    chk({name, "_done"}, int'(d0_pend), 0);
    if (exp_n >= 0) chk({name, "_cycles"}, n, exp_n);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (d0_hve !== e.d0.hve || d0_ls !== e.d0.ls || d0_fs !== e.d0.fs ||
          int'(d0_x) != e.d0.x || int'(d0_y) != e.d0.y ||
          d3_hve !== e.d3.hve || d3_ls !== e.d3.ls || d3_fs !== e.d3.fs ||
          int'(d3_x) != e.d3.x || int'(d3_y) != e.d3.y ||
          int'(d0_fc) != e.fc || int'(d3_fc) != e.fc ||
          d0_pend !== e.pend || d0_err !== e.err) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t d0 x=%0d y=%0d hve=%b ls=%b fs=%b (exp %0d %0d %b %b %b) d3 x=%0d y=%0d hve=%b ls=%b fs=%b (exp %0d %0d %b %b %b) fc=%0d exp %0d pend=%b exp %b err=%b exp %b",
                 $time, d0_x, d0_y, d0_hve, d0_ls, d0_fs, e.d0.x, e.d0.y, e.d0.hve, e.d0.ls, e.d0.fs,
                 d3_x, d3_y, d3_hve, d3_ls, d3_fs, e.d3.x, e.d3.y, e.d3.hve, e.d3.ls, e.d3.fs,
                 d0_fc, e.fc, d0_pend, e.pend, d0_err, e.err);
      end
    end
  end

  initial begin
    cfg_a   = '{hr: 8, hf: 2, hs: 3, hb: 1, vr: 4, vf: 1, vs: 1, vb: 2, hp: 1'b0, vp: 1'b0};
    cfg_b   = '{hr: 5, hf: 1, hs: 2, hb: 2, vr: 3, vf: 0, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
    cfg_c   = '{hr: 6, hf: 0, hs: 1, hb: 0, vr: 2, vf: 1, vs: 1, vb: 0, hp: 1'b0, vp: 1'b0};
    cfg_bad = '{hr: 8, hf: 2, hs: 0, hb: 1, vr: 4, vf: 1, vs: 1, vb: 2, hp: 1'b0, vp: 1'b0};
    rst_tap = '{hve: 3'b011, ls: 1'b0, fs: 1'b0, x: -6, y: -4};
    rst = 1'b1; en = 1'b1; wr = 1'b0;
    drive(cfg_a);
    cyc(); cyc();
    chk("rst_d0_x", int'(d0_x), -6);
    chk("rst_d0_y", int'(d0_y), -4);
    chk("rst_d0_hve", int'(d0_hve), 3);
    chk("rst_d0_fs", int'(d0_fs), 1);
    chk("rst_d3_x", int'(d3_x), -6);
    chk("rst_d3_ls", int'(d3_ls), 0);
    chk("rst_dd_x", int'(dd_x), -160);
    chk("rst_dd_y", int'(dd_y), -45);
    chk("rst_dd_hve", int'(dd_hve), 3);
    chk("rst_fc", int'(d0_fc), 0);
    chk("rst_pend", int'(d0_pend), 0);
    rst = 1'b0;

    for (int i = 1; i <= 800; i++) begin
      cyc();
      if (i == 14)  begin chk("d0_line_x", int'(d0_x), -6); chk("d0_line_y", int'(d0_y), -3); end
      if (i == 15)  chk("dd_hs_before", int'(dd_hve[0]), 1);
      if (i == 16)  chk("dd_hs_first", int'(dd_hve[0]), 0);
      if (i == 111) chk("dd_hs_last", int'(dd_hve[0]), 0);
      if (i == 112) begin chk("dd_hs_after", int'(dd_hve[0]), 1); chk("d0_fc_1", int'(d0_fc), 1); end
      if (i == 160) begin chk("dd_x0", int'(dd_x), 0); chk("dd_de_vblank", int'(dd_hve[2]), 0); end
      if (i == 800) begin
        chk("dd_line_x", int'(dd_x), -160); chk("dd_line_y", int'(dd_y), -44);
        chk("dd_line_ls", int'(dd_ls), 1); chk("d0_fc_7", int'(d0_fc), 7);
      end
    end

    drive(cfg_bad); wr = 1'b1; cyc(); wr = 1'b0;
    chk("err_pulse", int'(d0_err), 1);
    chk("err_no_pend", int'(d0_pend), 0);
    cyc();
    chk("err_clear", int'(d0_err), 0);

    drive(cfg_b); wr = 1'b1; cyc(); wr = 1'b0;
    chk("b_pend", int'(d0_pend), 1);
    wait_apply("b_apply", 93);
    chk("b_x", int'(d0_x), -5);
    chk("b_y", int'(d0_y), -2);
    chk("b_hve", int'(d0_hve), 2);
    repeat (10) cyc();
    chk("b_line_x", int'(d0_x), -5);
    chk("b_line_y", int'(d0_y), -1);

    drive(cfg_a); wr = 1'b1; cyc(); wr = 1'b0;
    for (int k = 0; k < 300 && !(mx == m_act.hr - 1 && my == m_act.vr - 1); k++) cyc();
    drive(cfg_c); wr = 1'b1; cyc(); wr = 1'b0;
    chk("wrapwr_pend", int'(d0_pend), 1);
    chk("wrapwr_x", int'(d0_x), -6);
    chk("wrapwr_y", int'(d0_y), -4);
    wait_apply("c_apply", 112);
    chk("c_x", int'(d0_x), -1);
    chk("c_y", int'(d0_y), -2);

    drive(cfg_b);
    repeat (5) cyc();
    en = 1'b0; wr = 1'b1; cyc(); wr = 1'b0;
    chk("dis_pend", int'(d0_pend), 1);
    repeat (9) cyc();
    en = 1'b1;
    wait_apply("dis_apply", -1);
    chk("dis_x", int'(d0_x), -5);
    chk("dis_y", int'(d0_y), -2);

    drive(cfg_c); wr = 1'b1; cyc(); wr = 1'b0;
    repeat (7) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mrst_x", int'(d0_x), -6);
    chk("mrst_y", int'(d0_y), -4);
    chk("mrst_pend", int'(d0_pend), 0);
    chk("mrst_hve", int'(d0_hve), 3);
    chk("mrst_d3_x", int'(d3_x), -6);
    repeat (112) cyc();
    chk("mrst_frame_x", int'(d0_x), -6);
    chk("mrst_frame_fs", int'(d0_fs), 1);
    repeat (2) cyc();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
Second-generation pixel timing generator. It turns the pixel clock into hsync, vsync, display-enable and signed x/y coordinates, plus frame and line strobes. Timing is reprogrammable at runtime through a shadow register set. New timing takes effect only at a frame boundary. An optional output delay line aligns the sync signals with downstream pixel pipelines. It sits between the pixel-clock PLL and the pattern/framebuffer and TMDS encoder path.

Parameters:
CW, 12, unsigned width of every timing field; o_x and o_y are CW+1 bits signed
DEF_H_RES / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, horizontal timing loaded at reset
DEF_V_RES / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, vertical timing loaded at reset
DEF_H_POL / DEF_V_POL, 0 / 0, sync active level (1 = active high)
PIPE_DELAY, 0, extra register stages applied equally to o_hvesync, o_frame_start, o_line_start, o_x and o_y (0..8)
FCW, 16, width of the frame counter

Ports:
i_pixel_clk  in  1  pixel clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  clock enable; when low, the whole block, including the delay line, holds its state
i_cfg_wr  in  1  one-cycle strobe that captures all i_cfg_* into the shadow set
i_cfg_h_res, i_cfg_h_fp, i_cfg_h_sync, i_cfg_h_bp  in  CW each  new horizontal timing
i_cfg_v_res, i_cfg_v_fp, i_cfg_v_sync, i_cfg_v_bp  in  CW each  new vertical timing
i_cfg_h_pol, i_cfg_v_pol  in  1 each  new sync polarities
o_hvesync  out  3  {display_enable, vsync, hsync}
o_frame_start  out  1  one-pixel pulse at the first pixel of a frame
o_line_start  out  1  one-pixel pulse at the first pixel of every line
o_x, o_y  out  CW+1 signed  coordinates; negative in blanking, 0..res-1 in the active area
o_frame_count  out  FCW  completed-frame counter, not delayed
o_cfg_pending  out  1  shadow set is loaded and not yet applied
o_cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Line order: front porch, sync, back porch, active.
  - H_START = -(fp+sync+bp); HSYNC_START = -(sync+bp); HSYNC_END = -bp.
  - Same structure vertically, counted in lines.
- x counts H_START..h_res-1, advancing by 1 per enabled cycle. At h_res-1, x returns to H_START and y increments. At y = v_res-1, y returns to V_START.
- hsync = pol when HSYNC_START <= x < HSYNC_END, otherwise ~pol; vsync is defined the same way on y. display_enable = (x>=0 && y>=0).
- o_line_start = (x==H_START). o_frame_start = (x==H_START && y==V_START).
- Arithmetic is signed CW+1. The legal range is fp+sync+bp <= 2^CW-1 and res <= 2^CW-1; behaviour outside this range is undefined.
- Config write:
  - i_cfg_wr with any res or sync field equal to 0: write ignored, shadow unchanged, o_cfg_err=1 for one cycle.
  - Porches may be 0.
  - A valid write loads the shadow set and sets o_cfg_pending=1.
  - A later write before the apply overwrites the shadow set; last write wins.
- Apply: on the enabled cycle where x==h_res-1 && y==v_res-1 (frame wrap), the active set takes the shadow set if pending, and pending clears. In the same cycle x and y load the new H_START and V_START, so the first pixel of the new frame already uses the new timing.
- Write on the apply cycle: the previously pending set applies. The new write is captured into the shadow set and o_cfg_pending stays 1.
- A write issued while nothing is pending applies at the next frame wrap, never mid-frame.
- o_frame_count increments modulo 2^FCW on each frame wrap.
- Delay line: with PIPE_DELAY=N, all five delayed outputs equal the undelayed values from N enabled cycles earlier. When N=0, these outputs are combinational from the counter registers.
- Reset values:
  - Active set = DEF_*; shadow cleared; pending=0; err=0; frame_count=0.
  - x=H_START, y=V_START of the defaults.
  - All delay stages hold {de=0, vsync=~DEF_V_POL, hsync=~DEF_H_POL}, strobes=0, x/y=default starts.
  - Outputs equal these values for the first cycle after reset.
- Reset mid-frame discards the current position, any pending config and the delay-line contents, then restarts from the defaults.
- i_enable=0: counters, delay line, frame counter and outputs all hold. i_cfg_wr is still accepted while i_enable=0.

Test Plan:
- Default reset, run 420000 cycles: line period 800; hsync=0 exactly for x=-144..-49; de high for 640x480 pixels per frame; frame_start pulses 420000 cycles apart; o_frame_count=1 after the first wrap.
- Mid-frame write of 1280x720 (h 110/40/220, v 5/5/20, pol 1/1): current frame finishes at 800x525. At wrap, x=-370 and y=-30; line period 1650; frame 750 lines; hsync=1 for x=-260..-221; o_cfg_pending falls on the apply cycle.
- Write with i_cfg_h_sync=0: o_cfg_err pulses once; o_cfg_pending stays 0; timing unchanged.
- Write exactly on the wrap cycle while a set is pending: the old pending set applies; the new set applies at the following wrap; pending is 1 in between.
- PIPE_DELAY=3 instance beside a PIPE_DELAY=0 instance: all delayed outputs match with a 3-cycle lag. Hold i_enable=0 for 10 cycles: both instances freeze, and the lag is still 3 enabled cycles.
- Reset at x=100, y=200 with a set pending: next cycle shows x=-160, y=-45, pending=0, de=0, hsync=1, vsync=1.
